axi_logger_ctrl: RTL and testbench

//  Run controller for a pair of AXI BRAM loggers (AR and AW channel loggers).
//  - Sequences arm/clear/run/stop and owns the loggers' shared Clear input.
//  - Gates the AXI valid seen by the loggers via LogEn_SO.
//  - Raises a full interrupt and exposes a 4-register host interface
//    (control, command, status, run-cycle counter).
//  - Sits between the host config bus and the loggers' Clear_SI/Full_SO pins.

---
 rtl/axi_logger_ctrl.sv | 87 ++++++++
 tb/tb_axi_logger_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axi_logger_ctrl.sv
// axi_logger_ctrl: run controller for the AR/AW BRAM loggers, sequencing clear/run/stop
// and exposing CTRL/CMD/STATUS/RUNCNT registers plus a full interrupt.
module axi_logger_ctrl #(
  parameter int CLEAR_CYCLES  = 2,
  parameter int RUNCNT_BITW   = 32,
  parameter int REG_ADDR_BITW = 4
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic                     RegWrEn_SI,
  input  logic                     RegRdEn_SI,
  input  logic [REG_ADDR_BITW-1:0] RegAddr_DI,
  input  logic [31:0]              RegWrData_DI,
  output logic [31:0]              RegRdData_DO,
  input  logic                     ArFull_SI,
  input  logic                     AwFull_SI,
  output logic                     Clear_SO,
  output logic                     LogEn_SO,
  output logic                     IrqFull_SO
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int IW = REG_ADDR_BITW - 2;
  typedef enum logic [1:0] {S_DIS, S_CLR, S_RUN, S_STOP} state_t;
  state_t                 r_state, w_nxt;
  logic [2:0]             r_ctrl, w_ctrl_nxt;
  logic [CW-1:0]          r_clr_cnt;
  logic [RUNCNT_BITW-1:0] r_runcnt;
  logic                   r_full_d, r_pend, r_irq;
  logic [31:0]            r_rd;
  logic [IW-1:0]          w_idx;
  logic                   w_wr_ctrl, w_wr_cmd, w_clr, w_ack, w_full, w_edge, w_enter_clr, w_pend_nxt;
  logic [31:0]            w_rd_data;
  logic                   w_unused;
  assign w_idx       = RegAddr_DI[REG_ADDR_BITW-1:2];
  assign w_wr_ctrl   = RegWrEn_SI && w_idx == IW'(0);
  assign w_wr_cmd    = RegWrEn_SI && w_idx == IW'(1);
  assign w_clr       = w_wr_cmd && RegWrData_DI[0];
  assign w_ack       = w_wr_cmd && RegWrData_DI[1];
  assign w_ctrl_nxt  = w_wr_ctrl ? RegWrData_DI[2:0] : r_ctrl;
  assign w_full      = ArFull_SI | AwFull_SI;
  assign w_edge      = w_full && !r_full_d && r_state == S_RUN;
  assign w_enter_clr = w_nxt == S_CLR && r_state != S_CLR;
  // Entering CLEAR beats a same-cycle full edge; a full edge beats ACK.
  assign w_pend_nxt  = w_enter_clr ? 1'b0 : w_edge ? 1'b1 : w_ack ? 1'b0 : r_pend;
  assign w_rd_data   = w_idx == IW'(0) ? {29'b0, r_ctrl} :
                       w_idx == IW'(2) ? {27'b0, r_pend, AwFull_SI, ArFull_SI, r_state} :
                       w_idx == IW'(3) ? 32'(r_runcnt) : 32'b0;
  assign w_unused    = ^{RegWrData_DI[31:3], RegAddr_DI[1:0]};
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) r_state <= S_DIS;
    else          r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_DIS:   w_nxt = (w_clr || (w_wr_ctrl && RegWrData_DI[0] && !r_ctrl[0])) ? S_CLR : S_DIS;
      S_CLR:   w_nxt = r_clr_cnt != CW'(CLEAR_CYCLES - 1) ? S_CLR : w_ctrl_nxt[0] ? S_RUN : S_DIS;
      S_RUN:   w_nxt = w_clr ? S_CLR : !w_ctrl_nxt[0] ? S_DIS : (w_full && w_ctrl_nxt[1]) ? S_STOP : S_RUN;
      default: w_nxt = w_clr ? S_CLR : !w_ctrl_nxt[0] ? S_DIS : S_STOP;
    endcase
  end
  always_comb begin
    Clear_SO   = r_state == S_CLR;
    LogEn_SO   = r_state == S_RUN;
    IrqFull_SO = r_irq;
  end
  assign RegRdData_DO = r_rd;
  always_ff @(posedge Clk_CI or negedge Rst_RBI)
    if (!Rst_RBI) begin
      r_ctrl    <= '0;
      r_clr_cnt <= '0;
      r_runcnt  <= '0;
      r_full_d  <= 1'b0;
      r_pend    <= 1'b0;
      r_irq     <= 1'b0;
      r_rd      <= '0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      r_clr_cnt <= r_state == S_CLR ? r_clr_cnt + CW'(1) : '0;
      r_runcnt  <= r_state == S_CLR ? '0 :
                   (r_state == S_RUN && !(&r_runcnt)) ? r_runcnt + RUNCNT_BITW'(1) : r_runcnt;
      // Held low through CLEAR so a full still asserted afterwards re-triggers in RUN.
      r_full_d  <= (r_state == S_CLR || w_nxt == S_CLR) ? 1'b0 : w_full;
      r_pend    <= w_pend_nxt;
      r_irq     <= w_pend_nxt & w_ctrl_nxt[2];
      if (RegRdEn_SI) r_rd <= w_rd_data;
    end
endmodule

// File: tb/tb_axi_logger_ctrl.sv
// tb_axi_logger_ctrl: directed bench for axi_logger_ctrl; a second instance with a
// 4-bit run counter covers saturation and asynchronous reset during CLEAR.
module tb_axi_logger_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, rst4_n = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, ar_full = 1'b0, aw_full = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0, rd, rd4;
  logic        clear, logen, irq, clear4, logen4, irq4;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  axi_logger_ctrl dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .RegWrEn_SI(wr_en), .RegRdEn_SI(rd_en),
    .RegAddr_DI(addr), .RegWrData_DI(wdata), .RegRdData_DO(rd),
    .ArFull_SI(ar_full), .AwFull_SI(aw_full),
    .Clear_SO(clear), .LogEn_SO(logen), .IrqFull_SO(irq));

  axi_logger_ctrl #(.RUNCNT_BITW(4)) dut4 (
    .Clk_CI(clk), .Rst_RBI(rst4_n), .RegWrEn_SI(wr_en), .RegRdEn_SI(rd_en),
    .RegAddr_DI(addr), .RegWrData_DI(wdata), .RegRdData_DO(rd4),
    .ArFull_SI(ar_full), .AwFull_SI(aw_full),
    .Clear_SO(clear4), .LogEn_SO(logen4), .IrqFull_SO(irq4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rdreg(input logic [3:0] a);
    addr = a; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst4_n = 1'b0;
    repeat (3) step();
    checks++; if ({clear, logen, irq} !== 3'b000) begin failures++; $display("FAIL reset_outs got=%b exp=000", {clear, logen, irq}); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd); end
    rst_n = 1'b1; rst4_n = 1'b1;
    rdreg(4'h8);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", rd); end
  endtask

  task automatic test_enable();
    wr(4'h0, 32'h1);
    checks++; if ({clear, logen} !== 2'b10) begin failures++; $display("FAIL en_t1 clear,logen got=%b exp=10", {clear, logen}); end
    step();
    checks++; if ({clear, logen} !== 2'b10) begin failures++; $display("FAIL en_t2 clear,logen got=%b exp=10", {clear, logen}); end
    step();
    checks++; if ({clear, logen} !== 2'b01) begin failures++; $display("FAIL en_t3 clear,logen got=%b exp=01", {clear, logen}); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL en_status got=%h exp=2", rd); end
    rdreg(4'h0);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL en_ctrl got=%h exp=1", rd); end
    rdreg(4'h4);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL cmd_read got=%h exp=0", rd); end
  endtask

  task automatic test_full_stop();
    wr(4'h0, 32'h7);
    ar_full = 1'b1;
    step();
    ar_full = 1'b0;
    checks++; if ({logen, irq} !== 2'b01) begin failures++; $display("FAIL stop logen,irq got=%b exp=01", {logen, irq}); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h13) begin failures++; $display("FAIL stop_status got=%h exp=13", rd); end
    wr(4'h4, 32'h2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack got=%b exp=0", irq); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL ack_status got=%h exp=3", rd); end
  endtask

  task automatic test_runcnt();
    wr(4'h4, 32'h1);
    checks++; if (clear !== 1'b1) begin failures++; $display("FAIL rc_clear got=%b exp=1", clear); end
    step(); step();
    checks++; if (logen !== 1'b1) begin failures++; $display("FAIL rc_run got=%b exp=1", logen); end
    rdreg(4'hC);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rc_zero got=%0d exp=0", rd); end
    repeat (99) step();
    rdreg(4'hC);
    checks++; if (rd !== 32'd100) begin failures++; $display("FAIL rc_100 got=%0d exp=100", rd); end
    wr(4'h4, 32'h1);
    checks++; if ({clear, logen} !== 2'b10) begin failures++; $display("FAIL rc_reclear got=%b exp=10", {clear, logen}); end
    step(); step();
    rdreg(4'hC);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL rc_cleared got=%0d exp=0", rd); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL rc_status got=%h exp=2", rd); end
  endtask

  task automatic test_rdwr();
    addr = 4'h0; wdata = 32'h3; wr_en = 1'b1; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (rd !== 32'h7) begin failures++; $display("FAIL rdwr_pre got=%h exp=7", rd); end
    rdreg(4'h0);
    checks++; if (rd !== 32'h3) begin failures++; $display("FAIL rdwr_post got=%h exp=3", rd); end
  endtask

  task automatic test_clr_vs_full();
    wr(4'h0, 32'h7);
    addr = 4'h4; wdata = 32'h1; wr_en = 1'b1; aw_full = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if ({clear, irq} !== 2'b10) begin failures++; $display("FAIL cvf_clear clear,irq got=%b exp=10", {clear, irq}); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h9) begin failures++; $display("FAIL cvf_status got=%h exp=9", rd); end
    checks++; if ({clear, irq} !== 2'b10) begin failures++; $display("FAIL cvf_clear2 got=%b exp=10", {clear, irq}); end
    step();
    checks++; if ({logen, irq} !== 2'b10) begin failures++; $display("FAIL cvf_run got=%b exp=10", {logen, irq}); end
    step();
    checks++; if ({logen, irq} !== 2'b01) begin failures++; $display("FAIL cvf_retrig got=%b exp=01", {logen, irq}); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h1B) begin failures++; $display("FAIL cvf_stop_status got=%h exp=1b", rd); end
    aw_full = 1'b0;
    wr(4'h4, 32'h2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cvf_ack got=%b exp=0", irq); end
  endtask

  task automatic test_clear_dis();
    wr(4'h4, 32'h1);
    wr(4'h4, 32'h1);
    checks++; if (clear !== 1'b1) begin failures++; $display("FAIL norestart_c2 got=%b exp=1", clear); end
    step();
    checks++; if ({clear, logen} !== 2'b01) begin failures++; $display("FAIL norestart_run got=%b exp=01", {clear, logen}); end
    wr(4'h4, 32'h1);
    wr(4'h0, 32'h0);
    checks++; if ({clear, logen} !== 2'b10) begin failures++; $display("FAIL dis_c2 got=%b exp=10", {clear, logen}); end
    step();
    checks++; if ({clear, logen} !== 2'b00) begin failures++; $display("FAIL dis_end got=%b exp=00", {clear, logen}); end
    rdreg(4'h8);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL dis_status got=%h exp=0", rd); end
    checks++; if (logen !== 1'b0) begin failures++; $display("FAIL dis_logen got=%b exp=0", logen); end
  endtask

  task automatic test_sat_async();
    wr(4'h0, 32'h1);
    step(); step();
    repeat (20) step();
    rdreg(4'hC);
    checks++; if (rd !== 32'd20) begin failures++; $display("FAIL sat_cnt32 got=%0d exp=20", rd); end
    checks++; if (rd4 !== 32'd15) begin failures++; $display("FAIL sat_cnt4 got=%0d exp=15", rd4); end
    wr(4'h0, 32'h0);
    checks++; if ({clear, logen} !== 2'b00) begin failures++; $display("FAIL run_dis got=%b exp=00", {clear, logen}); end
    wr(4'h4, 32'h1);
    checks++; if ({clear, clear4} !== 2'b11) begin failures++; $display("FAIL dis_clr got=%b exp=11", {clear, clear4}); end
    #2 rst4_n = 1'b0;
    #1;
    checks++; if ({clear, clear4} !== 2'b10) begin failures++; $display("FAIL async_rst got=%b exp=10", {clear, clear4}); end
    checks++; if (rd4 !== 32'h0) begin failures++; $display("FAIL async_rd got=%h exp=0", rd4); end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_full_stop();
    test_runcnt();
    test_rdwr();
    test_clr_vs_full();
    test_clear_dis();
    test_sat_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
